uart_tx_bridge_fifo: RTL and testbench



---
 rtl/uart_tx_bridge_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_bridge_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_bridge_fifo.sv
// Byte bridge from the core UART write port to a valid/ready serial sink.
// Provides a show-ahead FIFO, optional LF -> CR-LF expansion, an optional
// drop-on-full mode, an occupancy level and a saturating drop counter.
module uart_tx_bridge_fifo #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CRLF         = 1,
    parameter int unsigned DROP_ON_FULL = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              overflow_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Translation only makes sense for byte-wide payloads.
    localparam bit CrlfEn = (CRLF != 0) && (DATA_W == 8);
    localparam bit DropEn = (DROP_ON_FULL != 0);

    localparam logic [DATA_W-1:0] LfChar    = DATA_W'(10);
    localparam logic [DATA_W-1:0] CrChar    = DATA_W'(13);
    localparam logic [PW-1:0]     FullLevel = PW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StPendLf} state_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [15:0]       ovf_q;
    state_e            state_q, state_d;

    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              is_lf;
    logic [DATA_W-1:0] push_data;

    // Pointers carry an extra wrap bit, so their difference is the occupancy.
    assign level          = wr_ptr_q - rd_ptr_q;
    assign full           = (level == FullLevel);
    assign rd_valid       = (level != '0);
    assign rd_data        = mem[rd_ptr_q[AW-1:0]];
    assign pop            = rd_valid && rd_ready && !flush;
    assign overflow_count = ovf_q;

    // Next-state, write handshake and push/drop decisions.
    always_comb begin
        state_d   = state_q;
        wr_ready  = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        push_data = wr_data;
        is_lf     = CrlfEn && (wr_data == LfChar);
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // full is the pre-pop level; a same-cycle pop never frees a slot here.
                    wr_ready = !RST && (DropEn || !full);
                    if (wr_valid && wr_ready) begin
                        if (full) begin
                            drop = 1'b1;
                        end else if (is_lf) begin
                            push      = 1'b1;
                            push_data = CrChar;
                            state_d   = StPendLf;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                StPendLf: begin
                    // The deferred LF may use a slot freed by this cycle's pop.
                    if (!full || pop) begin
                        push      = 1'b1;
                        push_data = LfChar;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pointer, state and drop-counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
            state_q  <= StIdle;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_uart_tx_bridge_fifo.sv
// Directed bench: instance a uses CRLF=1 with stalling, instance b uses
// CRLF=0 with drop-on-full. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_uart_tx_bridge_fifo;

    logic        CLK;
    logic        RST;

    logic        a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready, a_flush;
    logic [7:0]  a_wr_data, a_rd_data;
    logic [4:0]  a_level;
    logic [15:0] a_ovf;

    logic        b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_flush;
    logic [7:0]  b_wr_data, b_rd_data;
    logic [4:0]  b_level;
    logic [15:0] b_ovf;

    int checks   = 0;
    int failures = 0;

    uart_tx_bridge_fifo #(
        .DATA_W(8), .DEPTH(16), .CRLF(1), .DROP_ON_FULL(0)
    ) dut_a (
        .CLK(CLK), .RST(RST),
        .wr_valid(a_wr_valid), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
        .flush(a_flush), .level(a_level), .overflow_count(a_ovf)
    );

    uart_tx_bridge_fifo #(
        .DATA_W(8), .DEPTH(16), .CRLF(0), .DROP_ON_FULL(1)
    ) dut_b (
        .CLK(CLK), .RST(RST),
        .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
        .flush(b_flush), .level(b_level), .overflow_count(b_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        a_wr_valid = 0; a_wr_data = 0; a_rd_ready = 0; a_flush = 0;
        b_wr_valid = 0; b_wr_data = 0; b_rd_ready = 0; b_flush = 0;

        // Reset state
        #3;
        chk("rst_a_wr_ready", a_wr_ready, 0);
        chk("rst_b_wr_ready", b_wr_ready, 0);
        chk("rst_a_level", a_level, 0);
        chk("rst_a_rd_valid", a_rd_valid, 0);
        chk("rst_b_ovf", b_ovf, 0);
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("post_rst_a_wr_ready", a_wr_ready, 1);

        // Basic order on b (CRLF off)
        b_wr_valid = 1;
        b_wr_data = 8'h41; tick();
        b_wr_data = 8'h42; tick();
        b_wr_data = 8'h43; tick();
        b_wr_valid = 0;
        chk("basic_level3", b_level, 3);
        chk("basic_d0", b_rd_data, 8'h41);
        b_rd_ready = 1;
        tick(); chk("basic_d1", b_rd_data, 8'h42);
        tick(); chk("basic_d2", b_rd_data, 8'h43);
        tick();
        chk("basic_empty_valid", b_rd_valid, 0);
        chk("basic_empty_level", b_level, 0);
        b_rd_ready = 0;

        // Backpressure on a: 17 writes into a 16-deep FIFO
        a_wr_valid = 1;
        for (int i = 1; i <= 16; i++) begin
            a_wr_data = 8'h60 + 8'(i);
            chk($sformatf("bp_wr_ready_%0d", i), a_wr_ready, 1);
            tick();
        end
        a_wr_data = 8'h71;
        chk("bp_full_wr_ready", a_wr_ready, 0);
        chk("bp_full_level", a_level, 16);
        tick();
        chk("bp_held_level", a_level, 16);
        chk("bp_held_head", a_rd_data, 8'h61);
        a_rd_ready = 1;
        tick();
        a_rd_ready = 0;
        chk("bp_after_pop_level", a_level, 15);
        chk("bp_after_pop_wr_ready", a_wr_ready, 1);
        tick();
        a_wr_valid = 0;
        chk("bp_byte17_level", a_level, 16);
        chk("bp_ovf", a_ovf, 0);
        a_rd_ready = 1;
        for (int i = 2; i <= 17; i++) begin
            chk($sformatf("bp_read_%0d", i), a_rd_data, 8'h60 + 8'(i));
            tick();
        end
        a_rd_ready = 0;
        chk("bp_drained", a_level, 0);

        // Drop mode on b: 20 writes
        b_wr_valid = 1;
        for (int i = 1; i <= 20; i++) begin
            b_wr_data = 8'h80 + 8'(i);
            chk($sformatf("drop_wr_ready_%0d", i), b_wr_ready, 1);
            tick();
        end
        b_wr_valid = 0;
        chk("drop_level", b_level, 16);
        chk("drop_ovf", b_ovf, 4);
        b_rd_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drop_read_%0d", i), b_rd_data, 8'h80 + 8'(i));
            tick();
        end
        b_rd_ready = 0;
        chk("drop_drained", b_rd_valid, 0);

        // CRLF translation on a
        a_wr_valid = 1;
        a_wr_data = 8'h41; tick();
        a_wr_data = 8'h0A;
        chk("crlf_lf_ready", a_wr_ready, 1);
        tick();
        a_wr_data = 8'h42;
        chk("crlf_pend_ready", a_wr_ready, 0);
        tick();
        chk("crlf_idle_ready", a_wr_ready, 1);
        tick();
        a_wr_valid = 0;
        chk("crlf_level", a_level, 4);
        a_rd_ready = 1;
        chk("crlf_r0", a_rd_data, 8'h41); tick();
        chk("crlf_r1", a_rd_data, 8'h0D); tick();
        chk("crlf_r2", a_rd_data, 8'h0A); tick();
        chk("crlf_r3", a_rd_data, 8'h42); tick();
        a_rd_ready = 0;
        chk("crlf_drained", a_level, 0);

        // PEND_LF while full
        a_wr_valid = 1;
        for (int i = 1; i <= 15; i++) begin
            a_wr_data = 8'h60 + 8'(i);
            tick();
        end
        a_wr_data = 8'h0A;
        tick();
        a_wr_valid = 0;
        chk("pend_full_level", a_level, 16);
        chk("pend_full_ready", a_wr_ready, 0);
        tick();
        chk("pend_hold_level", a_level, 16);
        a_rd_ready = 1;
        tick();
        a_rd_ready = 0;
        chk("pend_pop_level", a_level, 16);
        chk("pend_pop_head", a_rd_data, 8'h62);
        a_rd_ready = 1;
        for (int i = 2; i <= 15; i++) tick();
        chk("pend_tail_cr", a_rd_data, 8'h0D); tick();
        chk("pend_tail_lf", a_rd_data, 8'h0A); tick();
        a_rd_ready = 0;
        tick();
        chk("pend_drained_level", a_level, 0);
        chk("pend_idle_ready", a_wr_ready, 1);

        // Flush with level 5, concurrent write and read
        a_wr_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            a_wr_data = 8'h20 + 8'(i);
            tick();
        end
        chk("flush_pre_level", a_level, 5);
        a_wr_data = 8'h55;
        a_rd_ready = 1;
        a_flush = 1;
        b_flush = 1;
        #1;
        chk("flush_wr_ready", a_wr_ready, 0);
        tick();
        a_flush = 0; b_flush = 0; a_wr_valid = 0; a_rd_ready = 0;
        chk("flush_level", a_level, 0);
        chk("flush_rd_valid", a_rd_valid, 0);
        chk("flush_keeps_ovf", b_ovf, 4);

        // Async reset during PEND_LF
        a_wr_valid = 1;
        a_wr_data = 8'h31; tick();
        a_wr_data = 8'h0A; tick();
        a_wr_valid = 0;
        chk("mid_pend_ready", a_wr_ready, 0);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_level", a_level, 0);
        chk("arst_rd_valid", a_rd_valid, 0);
        chk("arst_ovf", b_ovf, 0);
        chk("arst_wr_ready", a_wr_ready, 0);
        tick();
        RST = 1'b0;
        tick();
        chk("arst_no_pending_lf", a_level, 0);
        chk("arst_idle_ready", a_wr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
